// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters for the RV32I fetch stage.
// Optional macro BP_GSHARE_EN indexes the counters by pc index XOR a global history register.
module branch_predictor #(
  parameter  int IDX_BITS = 5,
  localparam int TAG_BITS = 30 - IDX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_r   [ENTRIES];
  logic [TAG_BITS-1:0] tag_r     [ENTRIES];
  logic [31:0]         target_r  [ENTRIES];
  logic                is_jump_r [ENTRIES];
  logic [1:0]          ctr_r     [ENTRIES];

  logic [IDX_BITS-1:0] if_idx_s;
  logic [TAG_BITS-1:0] if_tag_s;
  logic [IDX_BITS-1:0] ex_idx_s;
  logic [TAG_BITS-1:0] ex_tag_s;
  logic [IDX_BITS-1:0] pht_rd_idx_s;
  logic [IDX_BITS-1:0] pht_wr_idx_s;
  logic                if_hit_s;
  logic                ex_hit_s;
  logic                upd_s;
  logic                taken_s;
  logic                wr_s;
  logic [1:0]          ctr_nxt_s;
  logic                unused_s;

  assign if_idx_s = if_pc[IDX_BITS+1:2];
  assign if_tag_s = if_pc[31:IDX_BITS+2];
  assign ex_idx_s = ex_pc[IDX_BITS+1:2];
  assign ex_tag_s = ex_pc[31:IDX_BITS+2];
  assign unused_s = ^{if_pc[1:0], ex_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_r;

  // Both predict and update use the history as it stands before this edge's shift
  assign pht_rd_idx_s = if_idx_s ^ ghr_r;
  assign pht_wr_idx_s = ex_idx_s ^ ghr_r;

  // Global history shifts in each resolved conditional branch outcome
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_r <= {IDX_BITS{1'b0}};
    end else if (upd_s && !ex_is_jump) begin
      ghr_r <= {ghr_r[IDX_BITS-2:0], ex_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end
`else
  assign pht_rd_idx_s = if_idx_s;
  assign pht_wr_idx_s = ex_idx_s;
`endif

  // Zero-latency prediction from the current (pre-update) table contents
  always_comb begin
    if_hit_s   = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    pred_taken = if_hit_s && (is_jump_r[if_idx_s] || ctr_r[pht_rd_idx_s][1]);
    if (pred_taken) begin
      pred_next_pc = target_r[if_idx_s];
    end else begin
      pred_next_pc = if_pc + 32'd4;
    end
  end

  // Training decision: jumps win over branches and always count as taken
  always_comb begin
    upd_s    = ex_valid && (ex_is_branch || ex_is_jump);
    taken_s  = ex_is_jump || ex_taken;
    ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    wr_s     = upd_s && (ex_hit_s || taken_s);
    if (ex_is_jump) begin
      ctr_nxt_s = 2'b11;
    end else if (!ex_hit_s) begin
      ctr_nxt_s = 2'b10;
    end else if (taken_s) begin
      ctr_nxt_s = (ctr_r[pht_wr_idx_s] == 2'b11) ? 2'b11 : ctr_r[pht_wr_idx_s] + 2'b01;
    end else begin
      ctr_nxt_s = (ctr_r[pht_wr_idx_s] == 2'b00) ? 2'b00 : ctr_r[pht_wr_idx_s] - 2'b01;
    end
  end

  // Single write port; reset clears the table and overrides any same-edge update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'b01;
      end
    end else if (wr_s) begin
      valid_r[ex_idx_s]   <= 1'b1;
      tag_r[ex_idx_s]     <= ex_tag_s;
      target_r[ex_idx_s]  <= ex_target;
      is_jump_r[ex_idx_s] <= ex_is_jump;
      ctr_r[pht_wr_idx_s] <= ctr_nxt_s;
    end else begin
      valid_r[ex_idx_s] <= valid_r[ex_idx_s];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build; gshare check under BP_GSHARE_EN).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;

  int tests = 0;
  int fails = 0;
  int mis   = 0;

  branch_predictor dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic br, input logic jmp, input logic tk);
    ex_valid = 1'b1; ex_pc = pc; ex_target = tgt;
    ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic br, input logic jmp, input logic tk);
    set_upd(pc, tgt, br, jmp, tk);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic query(input string tag, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check({tag, "_next"}, pred_next_pc, exp_pc);
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h100;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_pc = 32'h0; ex_target = 32'h0; ex_taken = 1'b0;
    tick();
    tick();
    query("in_reset", 32'h100, 1'b0, 32'h104);
    reset = 1'b0;
    tick();
    query("after_reset", 32'h100, 1'b0, 32'h104);

    // first taken update with if_pc == ex_pc: old contents visible this cycle
    if_pc = 32'h100;
    set_upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    #1;
    check("same_cycle_old", {31'd0, pred_taken}, 32'd0);
    tick();
    ex_valid = 1'b0;
    query("same_cycle_new", 32'h100, 1'b1, 32'h80);

    // ctr 10 -> 01 -> 00
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    query("nt1", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    query("nt2", 32'h100, 1'b0, 32'h104);

    // ctr 00 -> 01 -> 10 -> 11 -> 11 (saturate), then one NT keeps it taken
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    query("t1", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    query("t2", 32'h100, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    query("sat_nt1", 32'h100, 1'b1, 32'h80);
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0);
    query("sat_nt2", 32'h100, 1'b0, 32'h104);

    // ex_valid low with everything else active: ctr stays 01
    set_upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    ex_valid = 1'b0;
    tick();
    query("no_valid", 32'h100, 1'b0, 32'h104);

    // aliasing at index 0
    upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
    query("alias_own", 32'h100, 1'b1, 32'h80);
    query("alias_other", 32'h180, 1'b0, 32'h184);
    upd(32'h180, 32'h40, 1'b1, 1'b0, 1'b1);
    query("evict_new", 32'h180, 1'b1, 32'h40);
    query("evict_old", 32'h100, 1'b0, 32'h104);

    // jumps ignore ex_taken; branch+jump together behaves as a jump
    upd(32'h200, 32'h300, 1'b0, 1'b1, 1'b0);
    query("jump", 32'h200, 1'b1, 32'h300);
    upd(32'h300, 32'h400, 1'b1, 1'b1, 1'b0);
    query("br_and_jmp", 32'h300, 1'b1, 32'h400);

    // miss not-taken allocates nothing
    upd(32'h500, 32'h80, 1'b1, 1'b0, 1'b0);
    query("miss_nt", 32'h500, 1'b0, 32'h504);
    query("miss_nt_keep", 32'h300, 1'b1, 32'h400);

    query("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // alternating T/N branch at 0x600, count mispredicts after warm-up
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'h600;
      #1;
      if (i >= 10 && pred_taken != ~i[0]) mis++;
      upd(32'h600, 32'h80, 1'b1, 1'b0, ~i[0]);
    end
`ifdef BP_GSHARE_EN
    check("alt_gshare_mis", mis, 32'd0);
`else
    check("alt_bimodal_mis", mis, 32'd6);
`endif

    // reset mid-run overrides a simultaneous taken update
    set_upd(32'h700, 32'h80, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ex_valid = 1'b0;
    query("rst_upd", 32'h700, 1'b0, 32'h704);
    query("rst_600", 32'h600, 1'b0, 32'h604);
    query("rst_300", 32'h300, 1'b0, 32'h304);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch target buffer (BTB) plus 2-bit saturating-counter direction predictor for the pipelined RV32I core.
- Sits in IF: gives a predicted next PC for the current fetch PC.
- Is trained from EX by the resolved branch outcome, which is the ALU branch condition, and by the resolved target.
- Direct downstream consumer of the ALU bcond result.

Parameters:
- IDX_BITS, 5, log2 of entry count (32 entries); index = pc[IDX_BITS+1:2].
- TAG_BITS, 30-IDX_BITS, tag width = pc[31:IDX_BITS+2] (derived; not overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- if_pc  input  32  current fetch PC
- pred_taken  output  1  prediction: redirect to BTB target
- pred_next_pc  output  32  predicted next fetch PC
- ex_valid  input  1  EX-stage instruction is valid (not bubble/flushed)
- ex_is_branch  input  1  EX instruction is a conditional branch
- ex_is_jump  input  1  EX instruction is JAL/JALR
- ex_pc  input  32  PC of EX instruction
- ex_target  input  32  resolved target address
- ex_taken  input  1  resolved outcome (ALU bcond for branches; 1 for jumps)

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), is_jump (1), ctr (2).
- Reset:
  - All valid cleared; all ctr = 2'b01 (weakly not-taken).
  - Outputs during/after reset: pred_taken = 0 and pred_next_pc = if_pc+4, since no entry hits.
  - Reset asserted mid-operation clears the table on that edge and overrides any simultaneous update.
- Prediction (combinational, zero latency):
  - hit = valid[i] & tag[i]==if_pc tag bits.
  - pred_taken = hit & (is_jump[i] | ctr[i][1]).
  - pred_next_pc = pred_taken ? target[i] : if_pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
- Update: on rising edge when !reset & ex_valid & (ex_is_branch | ex_is_jump), at index j from ex_pc.
  - Hit (valid & tag match):
    - Target overwritten with ex_target.
    - is_jump = ex_is_jump.
    - ctr saturating: taken -> min(ctr+1,3); not-taken -> max(ctr-1,0).
  - Miss, taken:
    - Allocate (overwrite any occupant): valid=1, tag, target, is_jump.
    - ctr = 2'b10 for branches, 2'b11 for jumps.
  - Miss, not-taken: no allocation, table unchanged.
  - Jumps: ex_taken ignored, treated as taken; ctr forced 2'b11.
- Ignored inputs:
  - ex_valid=0: no state change.
  - ex_is_branch and ex_is_jump both set: treated as jump.
- Same-cycle read/write to one index: prediction returns pre-update contents; the new value is visible the next cycle (no bypass).
- No stall input: the update is the single write port, and IF stalls do not affect it.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - IDX_BITS-bit global history register ghr, reset 0.
  - On every update with ex_is_branch=1 (not jumps), ghr <= {ghr[IDX_BITS-2:0], ex_taken}.
  - Direction ctr lives in a separate IDX_BITS-indexed counter table, indexed by pc index XOR ghr. Predict uses the current ghr; update uses the pre-shift ghr from the same cycle.
  - The BTB (valid/tag/target/is_jump) stays indexed by the plain pc index.
  - pred_taken = hit & (is_jump | ctr[pc_idx^ghr][1]).
- Undefined: ghr absent; behaviour exactly as above (bimodal).

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104. Same result for any PC after reset pulsed mid-run.
- One update (ex_pc=0x100, ex_is_branch=1, ex_taken=1, ex_target=0x80), then if_pc=0x100 -> pred_taken=1, pred_next_pc=0x80.
  - Two not-taken updates then give ctr 10->01->00 and pred_taken=0.
  - Three taken updates then give ctr 11, saturated.
- Aliasing: train 0x100 taken to 0x80, then query 0x180 (same index, different tag) -> pred_taken=0, 0x184. Training 0x180 taken to 0x40 evicts, and query 0x100 -> 0x104.
- Jump: ex_is_jump=1, ex_pc=0x200, ex_target=0x300, ex_taken=0 -> query 0x200 gives pred_taken=1, 0x300.
- Same cycle: if_pc=ex_pc=0x100 on the first taken update -> pred_taken=0 that cycle, 1 the next. ex_valid=0 with all other update inputs active -> no change.
- With BP_GSHARE_EN, alternating T/N branch at 0x100 (target 0x80) -> after warm-up, prediction matches the outcome every iteration. Without the macro, the same pattern mispredicts at least every other iteration.
